// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : boot_pkg
// Purpose  : Shared opcodes, header field positions and FSM state encoding
//            for the multicore boot loader.
// Revision : 1.0 - initial release
// ============================================================================
package boot_pkg;

  // Header opcodes
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_START = 4'd2;
  localparam logic [3:0] OP_HALT  = 4'd3;

  // Header field bit positions
  localparam int HDR_OP_MSB  = 31;
  localparam int HDR_OP_LSB  = 28;
  localparam int HDR_ID_MSB  = 27;
  localparam int HDR_ID_LSB  = 24;
  localparam int HDR_ARG_MSB = 15;
  localparam int HDR_ARG_LSB = 0;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/boot_hdr_decode.sv
`default_nettype none
// ============================================================================
// Module   : boot_hdr_decode
// Purpose  : Combinational header field extraction and range checks
//            (core id in range, word count zero / oversize, one-hot select).
// Revision : 1.0 - initial release
// ============================================================================
module boot_hdr_decode
  import boot_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int IMEM_DEPTH = 256
) (
  input  logic [31:0]          hdr,
  output logic [3:0]           opcode,
  output logic [3:0]           core_id,
  output logic [15:0]          count,
  output logic [NUM_CORES-1:0] mask,
  output logic [NUM_CORES-1:0] id_sel,
  output logic                 id_ok,
  output logic                 n_zero,
  output logic                 n_over
);

  // Bits 23:16 carry no meaning in any header
  logic unused_rsvd;
  assign unused_rsvd = ^hdr[23:16];

  assign opcode  = hdr[HDR_OP_MSB:HDR_OP_LSB];
  assign core_id = hdr[HDR_ID_MSB:HDR_ID_LSB];
  assign count   = hdr[HDR_ARG_MSB:HDR_ARG_LSB];
  assign mask    = count[NUM_CORES-1:0];

  assign id_ok   = (32'(core_id) < 32'(NUM_CORES));
  assign n_zero  = (count == 16'd0);
  assign n_over  = (32'(count) > 32'(IMEM_DEPTH));

  // One-hot core select; all zero when the id is out of range
  always_comb begin
    id_sel = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      id_sel[i] = (32'(core_id) == i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicore_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : multicore_boot_loader
// Purpose  : Host word-stream loader. Decodes LOAD/START/HALT headers, writes
//            program words into per-core instruction memories and holds each
//            core in reset until it is loaded and explicitly started.
// Revision : 1.0 - initial release
// ============================================================================
module multicore_boot_loader
  import boot_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [31:0]          s_data,
  output logic                 imem_we,
  output logic [3:0]           imem_core,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [31:0]          imem_wdata,
  output logic [NUM_CORES-1:0] core_rst,
  output logic [NUM_CORES-1:0] loaded,
  output logic                 busy,
  output logic                 err,
  input  logic                 err_clr
);

  // Decoded header view of the current input word
  logic [3:0]           hdr_opcode;
  logic [3:0]           hdr_core_id;
  logic [15:0]          hdr_count;
  logic [NUM_CORES-1:0] hdr_mask;
  logic [NUM_CORES-1:0] hdr_id_sel;
  logic                 hdr_id_ok;
  logic                 hdr_n_zero;
  logic                 hdr_n_over;

  boot_hdr_decode #(
    .NUM_CORES  (NUM_CORES),
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_hdr_decode (
    .hdr     (s_data),
    .opcode  (hdr_opcode),
    .core_id (hdr_core_id),
    .count   (hdr_count),
    .mask    (hdr_mask),
    .id_sel  (hdr_id_sel),
    .id_ok   (hdr_id_ok),
    .n_zero  (hdr_n_zero),
    .n_over  (hdr_n_over)
  );

  state_e               state_q,      state_d;
  logic [3:0]           cur_id_q,     cur_id_d;
  logic [NUM_CORES-1:0] cur_sel_q,    cur_sel_d;
  logic [ADDR_W:0]      addr_q,       addr_d;
  logic [15:0]          remain_q,     remain_d;
  logic [NUM_CORES-1:0] core_rst_q,   core_rst_d;
  logic [NUM_CORES-1:0] loaded_q,     loaded_d;
  logic                 err_q,        err_d;
  logic                 imem_we_q,    imem_we_d;
  logic [3:0]           imem_core_q,  imem_core_d;
  logic [ADDR_W-1:0]    imem_addr_q,  imem_addr_d;
  logic [31:0]          imem_wdata_q, imem_wdata_d;
  logic                 err_set;
  logic                 accept;

  // The extra counter bit only exists so a full-depth image never wraps
  logic unused_addr_msb;
  assign unused_addr_msb = addr_q[ADDR_W];

  // Ready whenever reset is released
  assign s_ready = rst;
  assign accept  = s_valid & s_ready;

  // Next-state: header parsing, data write staging, status updates
  always_comb begin
    state_d      = state_q;
    cur_id_d     = cur_id_q;
    cur_sel_d    = cur_sel_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    core_rst_d   = core_rst_q;
    loaded_d     = loaded_q;
    err_set      = 1'b0;
    imem_we_d    = 1'b0;
    imem_core_d  = imem_core_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          case (hdr_opcode)
            OP_LOAD: begin
              if (!hdr_id_ok || hdr_n_over) begin
                // Bad target: flag it and swallow the payload, if any
                err_set = 1'b1;
                if (!hdr_n_zero) begin
                  state_d  = ST_DRAIN;
                  remain_d = hdr_count;
                end
              end else begin
                core_rst_d = core_rst_q | hdr_id_sel;
                loaded_d   = loaded_q & ~hdr_id_sel;
                if (!hdr_n_zero) begin
                  state_d   = ST_LOAD;
                  cur_id_d  = hdr_core_id;
                  cur_sel_d = hdr_id_sel;
                  addr_d    = '0;
                  remain_d  = hdr_count;
                end
              end
            end
            OP_START: begin
              for (int i = 0; i < NUM_CORES; i++) begin
                if (hdr_mask[i]) begin
                  if (loaded_q[i]) core_rst_d[i] = 1'b0;
                  else             err_set       = 1'b1;
                end
              end
            end
            OP_HALT: begin
              core_rst_d = core_rst_q | hdr_mask;
            end
            default: begin
              err_set = 1'b1;
            end
          endcase
        end
        ST_LOAD: begin
          imem_we_d    = 1'b1;
          imem_core_d  = cur_id_q;
          imem_addr_d  = addr_q[ADDR_W-1:0];
          imem_wdata_d = s_data;
          addr_d       = addr_q + {{ADDR_W{1'b0}}, 1'b1};
          remain_d     = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            loaded_d = loaded_q | cur_sel_q;
            state_d  = ST_IDLE;
          end
        end
        ST_DRAIN: begin
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // A new error beats a simultaneous clear
    err_d = err_set | (err_q & ~err_clr);
  end

  // State and output registers; reset aborts any load in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cur_id_q     <= '0;
      cur_sel_q    <= '0;
      addr_q       <= '0;
      remain_q     <= '0;
      core_rst_q   <= '1;
      loaded_q     <= '0;
      err_q        <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_core_q  <= '0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_id_q     <= cur_id_d;
      cur_sel_q    <= cur_sel_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      core_rst_q   <= core_rst_d;
      loaded_q     <= loaded_d;
      err_q        <= err_d;
      imem_we_q    <= imem_we_d;
      imem_core_q  <= imem_core_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_core  = imem_core_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign loaded     = loaded_q;
  assign busy       = (state_q != ST_IDLE);
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_multicore_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicore_boot_loader
// Purpose  : Directed scoreboard bench for multicore_boot_loader. Expected
//            memory writes are queued as data words are issued; a negedge
//            monitor pops and compares every imem_we pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicore_boot_loader;

  localparam int NC    = 4;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = '0;
  logic          imem_we;
  logic [3:0]    imem_core;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [NC-1:0] core_rst;
  logic [NC-1:0] loaded;
  logic          busy;
  logic          err;
  logic          err_clr = 1'b0;

  typedef struct packed {
    logic [3:0]    core;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_exp;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_writes = 0;

  multicore_boot_loader #(
    .NUM_CORES  (NC),
    .IMEM_DEPTH (DEPTH),
    .ADDR_W     (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .imem_we    (imem_we),
    .imem_core  (imem_core),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .loaded     (loaded),
    .busy       (busy),
    .err        (err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One word presented for exactly one clock edge
  task automatic send(input logic [31:0] w);
    s_valid = 1'b1;
    s_data  = w;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Data word that must produce a memory write
  task automatic send_data(input logic [3:0] core, input logic [AW-1:0] addr, input logic [31:0] w);
    exp_q.push_back({core, addr, w});
    send(w);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  // Write monitor: every imem_we pulse must match the head of the queue
  always @(negedge clk) begin
    if (rst && imem_we === 1'b1) begin
      n_writes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got core %0d addr %0h data %0h, expected no write",
                 imem_core, imem_addr, imem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({imem_core, imem_addr, imem_wdata} !== mon_exp) begin
          n_fail++;
          $display("FAIL write_match: got core %0d addr %0h data %0h, expected core %0d addr %0h data %0h",
                   imem_core, imem_addr, imem_wdata, mon_exp.core, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  initial begin
    int busy_drop;
    int writes_before;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready",    32'(s_ready),    0);
    chk("rst_imem_we",    32'(imem_we),    0);
    chk("rst_imem_core",  32'(imem_core),  0);
    chk("rst_imem_addr",  32'(imem_addr),  0);
    chk("rst_imem_wdata", imem_wdata,      0);
    chk("rst_core_rst",   32'(core_rst),   32'hF);
    chk("rst_loaded",     32'(loaded),     0);
    chk("rst_busy",       32'(busy),       0);
    chk("rst_err",        32'(err),        0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(s_ready), 1);

    // Basic load of core 1 and start
    send(32'h1100_0003);
    chk("load1_busy",     32'(busy),     1);
    chk("load1_core_rst", 32'(core_rst), 32'hF);
    send_data(4'd1, 8'd0, 32'hAAAA_0001);
    send_data(4'd1, 8'd1, 32'hBBBB_0002);
    send_data(4'd1, 8'd2, 32'hCCCC_0003);
    chk("load1_loaded", 32'(loaded), 32'h2);
    chk("load1_idle",   32'(busy),   0);
    send(32'h2000_0002);
    chk("start1_core_rst", 32'(core_rst), 32'hD);
    chk("start1_err",      32'(err),      0);

    // START without a load
    send(32'h2000_0001);
    chk("start_unloaded_err",      32'(err),      1);
    chk("start_unloaded_core_rst", 32'(core_rst), 32'hD);
    pulse_err_clr();
    chk("err_clr", 32'(err), 0);

    // Oversize load to core 2 is drained with no writes
    send(32'h1200_0101);
    chk("oversize_err",  32'(err),  1);
    chk("oversize_busy", 32'(busy), 1);
    busy_drop = 0;
    for (int i = 0; i < 257; i++) begin
      send(32'hDEAD_0000 | 32'(i));
      if (i < 256 && busy !== 1'b1) busy_drop++;
    end
    chk("oversize_busy_held", 32'(busy_drop), 0);
    chk("oversize_idle",      32'(busy),      0);
    chk("oversize_loaded",    32'(loaded),    32'h2);
    pulse_err_clr();
    send(32'h1200_0001);
    send_data(4'd2, 8'd0, 32'h1234_5678);
    chk("after_drain_loaded", 32'(loaded), 32'h6);
    chk("after_drain_err",    32'(err),    0);

    // Reprogram a running core 0
    send(32'h1000_0001);
    send_data(4'd0, 8'd0, 32'h0000_00A0);
    send(32'h2000_0001);
    chk("core0_running", 32'(core_rst), 32'hC);
    send(32'h1000_0002);
    chk("reprog_core_rst", 32'(core_rst), 32'hD);
    chk("reprog_loaded",   32'(loaded),   32'h6);
    send_data(4'd0, 8'd0, 32'h0000_00B0);
    chk("reprog_mid_loaded", 32'(loaded), 32'h6);
    send_data(4'd0, 8'd1, 32'h0000_00B1);
    chk("reprog_done_loaded", 32'(loaded), 32'h7);

    // Full-depth load of core 3 with a gap after every word
    @(negedge clk);
    #1;
    writes_before = n_writes;
    send(32'h1300_0100);
    for (int i = 0; i < 256; i++) begin
      send_data(4'd3, 8'(i), 32'hC000_0000 | 32'(i));
      @(posedge clk);
      #1;
    end
    chk("full_writes", 32'(n_writes - writes_before), 256);
    chk("full_loaded", 32'(loaded), 32'hF);
    chk("full_idle",   32'(busy),   0);

    // Reset in the middle of a load
    send(32'h1100_0005);
    send_data(4'd1, 8'd0, 32'h5555_0000);
    send_data(4'd1, 8'd1, 32'h5555_0001);
    chk("midrst_busy", 32'(busy), 1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_s_ready",    32'(s_ready),    0);
    chk("midrst_imem_we",    32'(imem_we),    0);
    chk("midrst_imem_core",  32'(imem_core),  0);
    chk("midrst_imem_addr",  32'(imem_addr),  0);
    chk("midrst_imem_wdata", imem_wdata,      0);
    chk("midrst_core_rst",   32'(core_rst),   32'hF);
    chk("midrst_loaded",     32'(loaded),     0);
    chk("midrst_busy_low",   32'(busy),       0);
    chk("midrst_err",        32'(err),        0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(32'h1000_0001);
    send_data(4'd0, 8'd0, 32'h0BAD_F00D);
    chk("fresh_loaded", 32'(loaded), 32'h1);
    chk("fresh_idle",   32'(busy),   0);

    // START then HALT, unknown opcode, zero-length loads
    send(32'h2000_0001);
    chk("start0_core_rst", 32'(core_rst), 32'hE);
    send(32'h3000_0001);
    chk("halt0_core_rst", 32'(core_rst), 32'hF);
    chk("halt0_loaded",   32'(loaded),   32'h1);
    send(32'h7000_0000);
    chk("unknown_op_err", 32'(err), 1);
    pulse_err_clr();
    send(32'h1000_0000);
    chk("n0_loaded",   32'(loaded),   0);
    chk("n0_core_rst", 32'(core_rst), 32'hF);
    chk("n0_busy",     32'(busy),     0);
    chk("n0_err",      32'(err),      0);
    send(32'h1500_0000);
    chk("badid_n0_err",  32'(err),  1);
    chk("badid_n0_busy", 32'(busy), 0);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    chk("total_writes",     32'(n_writes),     266);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicore_boot_loader.md
# multicore_boot_loader

Program loader and core-release controller for `multicore_processor`. It sits upstream of the cores. It accepts a 32-bit word stream from a host link (UART/JTAG bridge), decodes load/start/halt commands, and writes program words into the selected core's instruction memory. It holds each core in reset until that core has been loaded and explicitly started, which replaces loading program files directly into memory at time zero.

## Interface
Parameters:
- `NUM_CORES`, 4: number of cores driven; 1..16.
- `IMEM_DEPTH`, 256: instruction memory depth per core, in 32-bit words.
- `ADDR_W`, `$clog2(IMEM_DEPTH)`: instruction memory word-address width.

Ports:
- `clk` (in, 1): single clock.
- `rst` (in, 1): reset, asynchronous and active-low.
- `s_valid` (in, 1): host word valid.
- `s_ready` (out, 1): loader accepts a word.
- `s_data` (in, 32): host word.
- `imem_we` (out, 1): instruction memory write strobe, one cycle.
- `imem_core` (out, 4): target core index for the write.
- `imem_addr` (out, ADDR_W): word address.
- `imem_wdata` (out, 32): instruction word.
- `core_rst` (out, NUM_CORES): per-core reset, active-high. This matches the core `rst` input.
- `loaded` (out, NUM_CORES): core holds a complete image.
- `busy` (out, 1): a LOAD or DRAIN is in progress.
- `err` (out, 1): sticky protocol error.
- `err_clr` (in, 1): synchronous clear of `err`.

## Operation
- A word is accepted when `s_valid && s_ready`. `s_ready` = 0 while `rst` is asserted and 1 otherwise, so the loader accepts one word per cycle in every state.
- Header format:
  - [31:28] opcode: 1 = LOAD, 2 = START, 3 = HALT.
  - [27:24] core id.
  - [15:0] LOAD word count N, or the core mask for START/HALT in bits [NUM_CORES-1:0].
- States: IDLE, LOAD, DRAIN.
- IDLE, LOAD header:
  - If id < NUM_CORES and 1 <= N <= IMEM_DEPTH: set `core_rst[id]` = 1, clear `loaded[id]`, set the address counter to 0 and the remaining count to N, and go to LOAD.
  - If N = 0: no writes, `loaded[id]` = 0, `core_rst[id]` = 1, stay in IDLE.
  - If id is out of range or N > IMEM_DEPTH: set `err` and go to DRAIN with remaining = N. When N = 0 and id is out of range, only set `err` and stay in IDLE.
- LOAD: each accepted word produces a write of the word to (id, addr), then addr increments and remaining decrements. After the Nth word: set `loaded[id]` and go to IDLE.
- DRAIN: consume the remaining words with no writes, then go to IDLE.
- IDLE, START: for each mask bit set:
  - if `loaded` = 1, clear `core_rst`;
  - if `loaded` = 0, leave `core_rst` held and set `err`.
  - Mask bits at or above NUM_CORES are ignored.
- IDLE, HALT: set `core_rst` for each mask bit. `loaded` is unchanged.
- Unknown opcode in IDLE: set `err`, consume the word, stay in IDLE.
- `err_clr` and a new error in the same cycle: the error wins and `err` stays 1.
- Address counter width is ADDR_W+1 internally. N = IMEM_DEPTH writes addresses 0..IMEM_DEPTH-1 with no wrap.

## Timing
- Reset values:
  - `s_ready` = 0, `imem_we` = 0, `imem_core`/`imem_addr`/`imem_wdata` = 0.
  - `core_rst` = all ones, `loaded` = 0, `busy` = 0, `err` = 0, state = IDLE.
- Write latency: `imem_we`/`imem_core`/`imem_addr`/`imem_wdata` are registered. They are valid the cycle after the data word is accepted, and `imem_we` lasts exactly one cycle per word.
- `core_rst`, `loaded`, `busy` and `err` update on the edge that accepts the relevant word.
- `loaded[id]` rises on the same edge as the final `imem_we` pulse, so no START can be accepted before the last write. At that edge the state is back to IDLE; the next word is parsed as a header on the following edge.
- Gaps (`s_valid` = 0) in LOAD or DRAIN stall the counters. There is no timeout.
- Reset asserted mid-LOAD aborts the load immediately:
  - all outputs return to reset values;
  - the partial image is left in memory;
  - `loaded` = 0.

## Structure
- Shared package `boot_pkg`:
  - opcode constants `OP_LOAD`, `OP_START`, `OP_HALT`;
  - header field bit positions;
  - state enum (IDLE, LOAD, DRAIN).
- One sub-module: `boot_hdr_decode`. This is the combinational header field extraction plus range check (id valid, N range), feeding the FSM.
- The FSM, counters, per-core status registers and the write register stage stay in `multicore_boot_loader`.

## Test plan
- Basic load and start:
  - Stimulus: LOAD core 1 with N = 3 (words A, B, C), then START mask 0b0010.
  - Required: three `imem_we` pulses to core 1 at addresses 0, 1, 2 carrying A, B, C, each one cycle after acceptance.
  - Required: `loaded` = 0b0010, then `core_rst` = 0b1101.
- START without a load:
  - Stimulus: START mask 0b0001 with no prior load.
  - Required: `err` = 1 and `core_rst[0]` stays 1.
  - Stimulus: `err_clr` pulse. Required: `err` = 0.
- Oversize load:
  - Stimulus: LOAD with N = IMEM_DEPTH+1 (257) to core 2.
  - Required: `err` = 1, no `imem_we` for 257 data words, `busy` high throughout, then IDLE.
  - Stimulus: next LOAD N = 1. Required: it works normally.
- Reprogram a running core:
  - Stimulus: core 0 started, then LOAD core 0 with N = 2.
  - Required: `core_rst[0]` = 1 and `loaded[0]` = 0 at the header edge; `loaded[0]` = 1 after the second word.
- Gaps and full-depth load:
  - Stimulus: `s_valid` toggling 1010… during LOAD N = 256.
  - Required: exactly 256 writes, last address 255, no wrap.
- Reset mid-load:
  - Stimulus: assert `rst` low after 2 of 5 words.
  - Required: all outputs return to reset values asynchronously.
  - Stimulus: next header after release. Required: decoded as a fresh command.
